demux1to4: RTL and testbench

DEMUX1TO4 -- requirements
Module: demux1to4

---
 rtl/demux1to4.sv | 114 +++++++++++
 tb/tb_demux1to4.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux1to4.sv
// demux1to4: one-entry buffered 1-to-4 demultiplexer with valid/ready handshakes.
// A word accepted on the input side is held and offered to the port selected by
// in_sel. in_ready passes through the held port's out_ready, so streaming to a
// ready consumer sustains one word per cycle.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - upstream offers a word
//   in_ready   - block accepts the offered word this cycle (combinational)
//   in_sel     - destination port index 0..3
//   in_data    - word to route
//   out_valid  - one-hot, bit i set when port i holds a word
//   out_ready  - per-port consumer ready
//   out_data   - held word, shared by all ports
//   out_cnt    - four 8-bit delivery counters, port i in [8i+7:8i]
//
// Build option: define DEMUX_CNT_EN to add out_cnt and the delivery counters.
module demux1to4 #(
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_sel,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]   out_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      sel_q;
  logic [1:0]      sel_d;
  logic [DW-1:0]   data_d;
  logic [3:0]      valid_d;
  logic            in_fire;
  logic            out_fire;

  // Ready when empty, or when the held word leaves this cycle; never in reset.
  always_comb begin
    in_ready = rst_n && ((state_q == EMPTY) || out_ready[sel_q]);
  end

  // Only the held port's ready matters, and only while a word is held.
  always_comb begin
    out_fire = (state_q == FULL) && out_ready[sel_q];
    in_fire  = in_valid && in_ready;
  end

  // Next-state and next-output logic; a new word replaces a departing one.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = out_data;
    valid_d = 4'b0000;
    if (in_fire) begin
      state_d = FULL;
      sel_d   = in_sel;
      data_d  = in_data;
    end else if (out_fire) begin
      state_d = EMPTY;
    end
    if (state_d == FULL) begin
      valid_d = 4'b0001 << sel_d;
    end
  end

  // State and held-word registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      sel_q     <= 2'd0;
      out_data  <= '0;
      out_valid <= 4'b0000;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      out_data  <= data_d;
      out_valid <= valid_d;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [4];

  // Per-port delivery counters, wrapping at 256; reset wins over a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else if (out_fire) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
    end
  end

  always_comb begin
    out_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
  end
`endif

endmodule

// File: tb/tb_demux1to4.sv
// Bench for demux1to4: directed scenarios plus random traffic, checked against
// a one-slot buffer model kept as plain variables.
module tb_demux1to4;

  localparam int unsigned DW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;
`ifdef DEMUX_CNT_EN
  logic [31:0]   out_cnt;
`endif

  demux1to4 #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a slot that either holds (sel, data) or is empty.
  bit      m_present;
  int      m_sel;
  int      m_data;
  int      m_cnt [4];

  int vectors;
  int checks;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare just after, then advance the model.
  task automatic step(input bit rst, input bit v, input int sel, input int data, input logic [3:0] rdy);
    bit exp_ready;
    bit in_x;
    bit out_x;
    logic [3:0] exp_valid;
    logic [31:0] exp_cnt;
    @(negedge clk);
    rst_n     = rst;
    in_valid  = v;
    in_sel    = 2'(sel);
    in_data   = DW'(data);
    out_ready = rdy;
    #1;
    vectors++;
    exp_ready = rst && (!m_present || rdy[m_sel]);
    exp_valid = m_present ? 4'(1 << m_sel) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
`ifdef DEMUX_CNT_EN
    exp_cnt = {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
    chk("out_cnt", out_cnt, exp_cnt);
`else
    exp_cnt = 32'd0;
`endif
    if (!rst) begin
      m_present = 0;
      m_sel     = 0;
      m_data    = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      in_x  = v && exp_ready;
      out_x = m_present && rdy[m_sel];
      if (out_x) m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 256;
      if (in_x) begin
        m_present = 1;
        m_sel     = sel;
        m_data    = data % (1 << DW);
      end else if (out_x) begin
        m_present = 0;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    checks      = 0;
    miscompares = 0;
    m_present   = 0;
    m_sel       = 0;
    m_data      = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;

    // Reset, then one word to port 2.
    step(0, 0, 0, 0, 4'b0000);
    step(0, 1, 3, 3, 4'b1111);
    step(1, 1, 2, 2, 4'b1111);
    step(1, 0, 1, 1, 4'b1111);
    chk("single_valid", 32'(out_valid), 32'h4);
    chk("single_data", 32'(out_data), 32'h2);
    step(1, 0, 0, 0, 4'b1111);
    chk("single_empty", 32'(out_valid), 32'h0);

    // Back-pressure on port 1, then release.
    step(1, 1, 1, 1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 2, 3, 4'b0000);
      chk("stall_valid", 32'(out_valid), 32'h2);
      chk("stall_ready", 32'(in_ready), 32'h0);
    end
    step(1, 0, 0, 0, 4'b0010);
    chk("release_ready", 32'(in_ready), 32'h1);
    step(1, 0, 0, 0, 4'b0000);

    // Streaming with no bubbles.
    step(1, 1, 0, 1, 4'b1111);
    step(1, 1, 3, 2, 4'b1111);
    chk("stream0", 32'(out_valid), 32'h1);
    step(1, 1, 1, 3, 4'b1111);
    chk("stream1", 32'(out_valid), 32'h8);
    step(1, 1, 0, 0, 4'b1111);
    chk("stream2", 32'(out_valid), 32'h2);
    step(1, 1, 2, 1, 4'b1111);
    chk("stream3", 32'(out_valid), 32'h1);
    step(1, 0, 0, 0, 4'b1111);
    chk("stream4", 32'(out_valid), 32'h4);
    step(1, 0, 0, 0, 4'b1111);

    // Ready on non-selected ports is ignored.
    step(1, 1, 3, 2, 4'b0000);
    step(1, 1, 0, 1, 4'b0111);
    step(1, 0, 0, 0, 4'b0111);
    chk("ignored_valid", 32'(out_valid), 32'h8);
    chk("ignored_data", 32'(out_data), 32'h2);

    // Reset while full, then release.
    step(0, 0, 0, 0, 4'b1111);
    chk("midrst_ready", 32'(in_ready), 32'h0);
    step(1, 0, 0, 0, 4'b1111);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_release", 32'(in_ready), 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom));
    end

`ifdef DEMUX_CNT_EN
    // Counter wrap: 257 deliveries to port 0.
    step(0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 257; i++) step(1, 1, 0, i, 4'b0001);
    step(1, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 0, 4'b0001);
    chk("cnt_wrap", out_cnt, 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
